// File: rtl/reorder_buffer.sv
// In-order commit buffer: entries are allocated at the tail, completed by index, and retired from the head.
// Define ROB_FLUSH_EN to add a flush input that discards every in-flight entry.
module reorder_buffer #(
  parameter int ROB_DEPTH      = 16,
  parameter int ROB_DEPTH_LOG2 = $clog2(ROB_DEPTH),
  parameter int NUM_REG        = 32,
  parameter int NUM_REG_LOG2   = $clog2(NUM_REG),
  parameter int NUM_TAGS       = 64,
  parameter int NUM_TAGS_LOG2  = $clog2(NUM_TAGS)
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef ROB_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      alloc_valid,
  input  logic [NUM_REG_LOG2-1:0]   alloc_rd,
  input  logic [NUM_TAGS_LOG2-1:0]  alloc_tag,
  input  logic [NUM_TAGS_LOG2-1:0]  alloc_free_tag,
  output logic                      alloc_ready,
  output logic [ROB_DEPTH_LOG2-1:0] alloc_idx,
  input  logic                      complete_valid,
  input  logic [ROB_DEPTH_LOG2-1:0] complete_idx,
  output logic                      retire_valid,
  output logic [NUM_REG_LOG2-1:0]   retire_rd,
  output logic [NUM_TAGS_LOG2-1:0]  retire_dest_tag,
  output logic                      retire_free,
  output logic [NUM_TAGS_LOG2-1:0]  retire_free_tag,
  output logic                      rob_empty,
  output logic                      rob_full
);

  localparam int PTR_W = ROB_DEPTH_LOG2 + 1;

  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic [ROB_DEPTH-1:0]      busy_q, busy_d, done_q, done_d;
  logic [NUM_REG_LOG2-1:0]   rd_q       [ROB_DEPTH];
  logic [NUM_REG_LOG2-1:0]   rd_d       [ROB_DEPTH];
  logic [NUM_TAGS_LOG2-1:0]  tag_q      [ROB_DEPTH];
  logic [NUM_TAGS_LOG2-1:0]  tag_d      [ROB_DEPTH];
  logic [NUM_TAGS_LOG2-1:0]  free_tag_q [ROB_DEPTH];
  logic [NUM_TAGS_LOG2-1:0]  free_tag_d [ROB_DEPTH];

  logic [ROB_DEPTH_LOG2-1:0] head_idx, tail_idx;
  logic                      empty, full, flush_active, alloc_fire;

`ifdef ROB_FLUSH_EN
  assign flush_active = flush;
`else
  assign flush_active = 1'b0;
`endif

  assign head_idx = head_q[ROB_DEPTH_LOG2-1:0];
  assign tail_idx = tail_q[ROB_DEPTH_LOG2-1:0];

  // The wrap bit distinguishes full from empty when the index bits match.
  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

  assign alloc_ready     = ~full & ~rst & ~flush_active;
  assign alloc_idx       = tail_idx;
  assign alloc_fire      = alloc_valid & alloc_ready;
  assign retire_valid    = ~empty & done_q[head_idx] & ~rst & ~flush_active;
  assign retire_rd       = rd_q[head_idx];
  assign retire_dest_tag = tag_q[head_idx];
  assign retire_free_tag = free_tag_q[head_idx];
  assign retire_free     = retire_valid & (retire_rd != '0);
  assign rob_empty       = empty;
  assign rob_full        = full;

  // Update order matters: retire clears after completion, allocation initialises last.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    busy_d     = busy_q;
    done_d     = done_q;
    rd_d       = rd_q;
    tag_d      = tag_q;
    free_tag_d = free_tag_q;

    if (complete_valid && busy_q[complete_idx]) begin
      done_d[complete_idx] = 1'b1;
    end

    if (retire_valid) begin
      busy_d[head_idx] = 1'b0;
      done_d[head_idx] = 1'b0;
      head_d           = head_q + PTR_W'(1);
    end

    if (alloc_fire) begin
      busy_d[tail_idx]     = 1'b1;
      done_d[tail_idx]     = 1'b0;
      rd_d[tail_idx]       = alloc_rd;
      tag_d[tail_idx]      = alloc_tag;
      free_tag_d[tail_idx] = alloc_free_tag;
      tail_d               = tail_q + PTR_W'(1);
    end

    if (flush_active) begin
      busy_d = '0;
      done_d = '0;
      head_d = head_q;
      tail_d = head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Payload storage needs no reset; busy/done gate every use of it.
  always_ff @(posedge clk) begin
    rd_q       <= rd_d;
    tag_q      <= tag_d;
    free_tag_q <= free_tag_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations push expected retirements, a negedge monitor pops and compares them.
// Build with ROB_FLUSH_EN defined to also exercise the flush scenario.
module tb_reorder_buffer;

  typedef struct {
    logic [4:0] rd;
    logic [5:0] tag;
    logic [5:0] free_tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid = 1'b0;
  logic [4:0] alloc_rd = '0;
  logic [5:0] alloc_tag = '0;
  logic [5:0] alloc_free_tag = '0;
  logic       alloc_ready;
  logic [3:0] alloc_idx;
  logic       complete_valid = 1'b0;
  logic [3:0] complete_idx = '0;
  logic       retire_valid;
  logic [4:0] retire_rd;
  logic [5:0] retire_dest_tag;
  logic       retire_free;
  logic [5:0] retire_free_tag;
  logic       rob_empty;
  logic       rob_full;
`ifdef ROB_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_exp;

  reorder_buffer dut (
    .clk             (clk),
    .rst             (rst),
`ifdef ROB_FLUSH_EN
    .flush           (flush),
`endif
    .alloc_valid     (alloc_valid),
    .alloc_rd        (alloc_rd),
    .alloc_tag       (alloc_tag),
    .alloc_free_tag  (alloc_free_tag),
    .alloc_ready     (alloc_ready),
    .alloc_idx       (alloc_idx),
    .complete_valid  (complete_valid),
    .complete_idx    (complete_idx),
    .retire_valid    (retire_valid),
    .retire_rd       (retire_rd),
    .retire_dest_tag (retire_dest_tag),
    .retire_free     (retire_free),
    .retire_free_tag (retire_free_tag),
    .rob_empty       (rob_empty),
    .rob_full        (rob_full)
  );

  always #5 clk = ~clk;

  // Every retirement must match the oldest outstanding allocation.
  always @(negedge clk) begin
    if (retire_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL retire_unexpected: got retire rd=%0d tag=%0d, required no retire", retire_rd, retire_dest_tag);
      end else begin
        mon_exp = sb.pop_front();
        if ({retire_rd, retire_dest_tag, retire_free, retire_free_tag} !==
            {mon_exp.rd, mon_exp.tag, (mon_exp.rd != 5'd0), mon_exp.free_tag}) begin
          errors++;
          $display("[TB] FAIL retire_payload: got rd=%0d tag=%0d free=%0b free_tag=%0d, required rd=%0d tag=%0d free=%0b free_tag=%0d",
                   retire_rd, retire_dest_tag, retire_free, retire_free_tag,
                   mon_exp.rd, mon_exp.tag, (mon_exp.rd != 5'd0), mon_exp.free_tag);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 1'b0;
    complete_valid = 1'b0;
    sb.delete();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alloc_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({alloc_ready, retire_valid, retire_free} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_active: got ready=%0b rv=%0b rf=%0b, required 0 0 0", alloc_ready, retire_valid, retire_free);
    end
    next_cycle();
    rst = 1'b0;
    alloc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rob_empty, rob_full, alloc_ready, retire_valid, retire_free, alloc_idx} !== {5'b10100, 4'd0}) begin
      errors++;
      $display("[TB] FAIL reset_idle: got empty=%0b full=%0b ready=%0b rv=%0b rf=%0b idx=%0d, required 1 0 1 0 0 0",
               rob_empty, rob_full, alloc_ready, retire_valid, retire_free, alloc_idx);
    end
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd5; alloc_tag = 6'd40; alloc_free_tag = 6'd5;
    @(negedge clk);
    checks++;
    if (alloc_idx !== 4'd0 || alloc_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_alloc: got idx=%0d ready=%0b, required 0 1", alloc_idx, alloc_ready);
    end
    sb.push_back('{5'd5, 6'd40, 6'd5});
    next_cycle();
    alloc_valid = 1'b0; complete_valid = 1'b1; complete_idx = 4'd0;
    @(negedge clk);
    checks++;
    if (retire_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early: got retire_valid=%0b, required 0", retire_valid);
    end
    next_cycle();
    complete_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (retire_valid !== 1'b1 || retire_free !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_retire: got rv=%0b rf=%0b, required 1 1", retire_valid, retire_free);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rob_empty !== 1'b1 || retire_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_empty: got empty=%0b rv=%0b, required 1 0", rob_empty, retire_valid);
    end
    next_cycle();
  endtask

  task automatic test_in_order();
    int ord[3] = '{2, 1, 0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 1); alloc_tag = 6'(10 + i); alloc_free_tag = 6'(20 + i);
      @(negedge clk);
      checks++;
      if (alloc_idx !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL order_alloc_idx: got %0d, required %0d", alloc_idx, i);
      end
      sb.push_back('{5'(i + 1), 6'(10 + i), 6'(20 + i)});
      next_cycle();
    end
    alloc_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      complete_valid = 1'b1; complete_idx = 4'(ord[j]);
      @(negedge clk);
      checks++;
      if (retire_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL order_hold: got retire_valid=%0b while completing %0d, required 0", retire_valid, ord[j]);
      end
      next_cycle();
    end
    complete_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (retire_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL order_retire_%0d: got retire_valid=%0b, required 1", j, retire_valid);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (rob_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL order_empty: got %0b, required 1", rob_empty);
    end
    next_cycle();
  endtask

  task automatic test_full();
    exp_t e;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      e.rd = 5'($urandom_range(1, 31)); e.tag = 6'($urandom); e.free_tag = 6'($urandom);
      alloc_valid = 1'b1; alloc_rd = e.rd; alloc_tag = e.tag; alloc_free_tag = e.free_tag;
      @(negedge clk);
      checks++;
      if (alloc_ready !== 1'b1 || alloc_idx !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL full_fill: got ready=%0b idx=%0d, required 1 %0d", alloc_ready, alloc_idx, i);
      end
      sb.push_back(e);
      next_cycle();
    end
    alloc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rob_full !== 1'b1 || alloc_ready !== 1'b0 || rob_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_flag: got full=%0b ready=%0b empty=%0b, required 1 0 0", rob_full, alloc_ready, rob_empty);
    end
    next_cycle();
    alloc_valid = 1'b1; alloc_rd = 5'd9; alloc_tag = 6'd9; alloc_free_tag = 6'd9;
    complete_valid = 1'b1; complete_idx = 4'd0;
    next_cycle();
    complete_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (retire_valid !== 1'b1 || alloc_ready !== 1'b0 || rob_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_retire_no_alloc: got rv=%0b ready=%0b full=%0b, required 1 0 1", retire_valid, alloc_ready, rob_full);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (alloc_ready !== 1'b1 || alloc_idx !== 4'd0 || rob_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_wrap: got ready=%0b idx=%0d full=%0b, required 1 0 0", alloc_ready, alloc_idx, rob_full);
    end
    sb.push_back('{5'd9, 6'd9, 6'd9});
    next_cycle();
    alloc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rob_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_refill: got full=%0b, required 1", rob_full);
    end
    next_cycle();
  endtask

  task automatic test_ignored_complete();
    int retires = 0;
    do_reset();
    complete_valid = 1'b1; complete_idx = 4'd7;
    @(negedge clk);
    checks++;
    if (rob_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_complete: got empty=%0b, required 1", rob_empty);
    end
    next_cycle();
    // Entry 0 targets x0; entry 7 is completed in the same cycle it is allocated.
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      alloc_rd = (i == 0) ? 5'd0 : 5'(i + 3);
      alloc_tag = (i == 0) ? 6'd0 : 6'(30 + i);
      alloc_free_tag = (i == 0) ? 6'd0 : 6'(50 + i);
      complete_valid = (i == 7); complete_idx = 4'd7;
      @(negedge clk);
      checks++;
      if (alloc_idx !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL ignore_alloc_idx: got %0d, required %0d", alloc_idx, i);
      end
      sb.push_back('{alloc_rd, alloc_tag, alloc_free_tag});
      next_cycle();
    end
    alloc_valid = 1'b0;
    complete_valid = 1'b1; complete_idx = 4'd0;
    next_cycle();
    complete_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (retire_valid !== 1'b1 || retire_free !== 1'b0) begin
      errors++;
      $display("[TB] FAIL x0_retire: got rv=%0b rf=%0b, required 1 0", retire_valid, retire_free);
    end
    next_cycle();
    for (int i = 1; i < 11; i++) begin
      complete_valid = (i < 7); complete_idx = 4'(i);
      @(negedge clk);
      if (retire_valid === 1'b1) retires++;
      next_cycle();
    end
    complete_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (retires != 6 || rob_empty !== 1'b0 || retire_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_entry7: got retires=%0d empty=%0b rv=%0b, required 6 0 0", retires, rob_empty, retire_valid);
    end
    next_cycle();
    complete_valid = 1'b1; complete_idx = 4'd7;
    next_cycle();
    complete_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (retire_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL entry7_retire: got rv=%0b, required 1", retire_valid);
    end
    next_cycle();
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 1); alloc_tag = 6'(i + 1); alloc_free_tag = 6'(i + 1);
      sb.push_back('{5'(i + 1), 6'(i + 1), 6'(i + 1)});
      next_cycle();
    end
    alloc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      complete_valid = (i < 2); complete_idx = 4'(i);
      next_cycle();
    end
    complete_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 11); alloc_tag = 6'(i + 11); alloc_free_tag = 6'(i + 11);
      @(negedge clk);
      checks++;
      if (alloc_idx !== 4'(i + 2)) begin
        errors++;
        $display("[TB] FAIL flush_alloc_idx: got %0d, required %0d", alloc_idx, i + 2);
      end
      sb.push_back('{5'(i + 11), 6'(i + 11), 6'(i + 11)});
      next_cycle();
    end
    alloc_valid = 1'b0;
    complete_valid = 1'b1; complete_idx = 4'd2;
    next_cycle();
    flush = 1'b1; complete_idx = 4'd3; alloc_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (retire_valid !== 1'b0 || alloc_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_gate: got rv=%0b ready=%0b, required 0 0", retire_valid, alloc_ready);
    end
    next_cycle();
    flush = 1'b0; complete_valid = 1'b0; alloc_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (rob_empty !== 1'b1 || retire_valid !== 1'b0 || alloc_idx !== 4'd2) begin
      errors++;
      $display("[TB] FAIL flush_state: got empty=%0b rv=%0b idx=%0d, required 1 0 2", rob_empty, retire_valid, alloc_idx);
    end
    next_cycle();
    alloc_valid = 1'b1; alloc_rd = 5'd7; alloc_tag = 6'd17; alloc_free_tag = 6'd27;
    sb.push_back('{5'd7, 6'd17, 6'd27});
    next_cycle();
    alloc_valid = 1'b0; complete_valid = 1'b1; complete_idx = 4'd2;
    next_cycle();
    complete_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (retire_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_after: got rv=%0b, required 1", retire_valid);
    end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_in_order();
    test_full();
    test_ignored_complete();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
